// File: rtl/wb_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_write_arbiter_pkg
// Description : Shared widths, queue-depth default, entry layout and the
//               zero-register constant for the writeback arbiter slice.
//               AWIDTH / DWIDTH may be overridden by defining the AWIDTH /
//               DWIDTH macros. Optional feature macro: WB_FWD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`ifndef AWIDTH
`define AWIDTH 5
`endif

`ifndef DWIDTH
`define DWIDTH 32
`endif

package wb_write_arbiter_pkg;

    localparam int AWIDTH = `AWIDTH;
    localparam int DWIDTH = `DWIDTH;

    // Default queue depth (power of two, >= 2)
    localparam int WB_DEPTH = 4;

    // Architectural $zero: writes to it are discarded
    localparam logic [AWIDTH-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [AWIDTH-1:0] addr;
        logic [DWIDTH-1:0] data;
    } wb_entry_t;

    function automatic logic is_writable(input logic [AWIDTH-1:0] addr);
        return addr != ZERO_REG;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_write_arbiter_if
// Description : Bundle between the dual-issue writeback pipes / forwarding
//               consumer (master) and the write arbiter (slave).
//               Lane inputs : w_i_valid0/1, w_i_addr0/1, w_i_data0/1
//               Query input : w_i_addr_q
//               Outputs     : w_o_ready, w_o_wr_en, w_o_addr_rd, w_o_data_rd,
//                             w_o_count, w_o_fwd_hit, w_o_fwd_data
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_write_arbiter_if
    import wb_write_arbiter_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) ();
    localparam int CW = $clog2(DEPTH) + 1;

    logic              w_i_valid0;
    logic [AWIDTH-1:0] w_i_addr0;
    logic [DWIDTH-1:0] w_i_data0;
    logic              w_i_valid1;
    logic [AWIDTH-1:0] w_i_addr1;
    logic [DWIDTH-1:0] w_i_data1;
    logic              w_o_ready;
    logic              w_o_wr_en;
    logic [AWIDTH-1:0] w_o_addr_rd;
    logic [DWIDTH-1:0] w_o_data_rd;
    logic [CW-1:0]     w_o_count;
    logic [AWIDTH-1:0] w_i_addr_q;
    logic              w_o_fwd_hit;
    logic [DWIDTH-1:0] w_o_fwd_data;

    modport master (
        output w_i_valid0, w_i_addr0, w_i_data0,
        output w_i_valid1, w_i_addr1, w_i_data1,
        output w_i_addr_q,
        input  w_o_ready, w_o_wr_en, w_o_addr_rd, w_o_data_rd,
        input  w_o_count, w_o_fwd_hit, w_o_fwd_data
    );

    modport slave (
        input  w_i_valid0, w_i_addr0, w_i_data0,
        input  w_i_valid1, w_i_addr1, w_i_data1,
        input  w_i_addr_q,
        output w_o_ready, w_o_wr_en, w_o_addr_rd, w_o_data_rd,
        output w_o_count, w_o_fwd_hit, w_o_fwd_data
    );

endinterface
`default_nettype wire

// File: rtl/wb_write_arbiter_fwd_search.sv
`default_nettype none
// ============================================================================
// Module      : wb_fwd_search
// Description : Youngest-first match of a query address against the occupied
//               entries of the circular writeback queue.
//               i_entries : queue storage      i_head  : oldest slot
//               i_count   : occupied entries   i_addr_q: query address
//               o_hit     : some pending write targets i_addr_q (never $zero)
//               o_data    : data of the youngest such write
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fwd_search
    import wb_write_arbiter_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  wire wb_entry_t         i_entries [DEPTH],
    input  wire logic [PW-1:0]     i_head,
    input  wire logic [CW-1:0]     i_count,
    input  wire logic [AWIDTH-1:0] i_addr_q,
    output logic                   o_hit,
    output logic [DWIDTH-1:0]      o_data
);
    logic [PW-1:0] w_idx;

    // Walk from oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        w_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = i_head + PW'(i);
            if ((CW'(i) < i_count) && is_writable(i_addr_q) &&
                (i_entries[w_idx].addr == i_addr_q)) begin
                o_hit  = 1'b1;
                o_data = i_entries[w_idx].data;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_write_arbiter
// Description : Serialises up to two in-order writeback results per cycle
//               (lane0 older than lane1) through a circular queue onto the
//               single register-file write port. Writes to $zero are dropped.
//               w_clk   : clock          w_rst_n : async active-low reset
//               bus     : wb_write_arbiter_if.slave (lanes, write port, count,
//                         forwarding query/result)
//               Optional: WB_FWD_EN builds the pending-write forwarding search;
//               otherwise fwd outputs are tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_write_arbiter
    import wb_write_arbiter_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  wire logic         w_clk,
    input  wire logic         w_rst_n,
    wb_write_arbiter_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    // Two free slots are needed so a dual push can never overflow.
    localparam logic [CW-1:0] c_ready_max = CW'(DEPTH - 2);

    wb_entry_t     r_q [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic          w_ready;
    logic          w_push0;
    logic          w_push1;
    logic          w_pop;
    logic [PW-1:0] w_slot1;
    logic [CW-1:0] w_count_nxt;

    // Ready looks only at registered occupancy, not at this cycle's drain.
    assign w_ready     = (r_count <= c_ready_max);
    assign w_push0     = w_ready & bus.w_i_valid0 & is_writable(bus.w_i_addr0);
    assign w_push1     = w_ready & bus.w_i_valid1 & is_writable(bus.w_i_addr1);
    assign w_pop       = (r_count != '0);
    // Lane1 lands behind lane0 only when lane0 actually took a slot.
    assign w_slot1     = r_tail + PW'(w_push0);
    assign w_count_nxt = r_count - CW'(w_pop) + CW'(w_push0) + CW'(w_push1);

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_q[i] <= '0;
            end
        end else begin
            if (w_push0) begin
                r_q[r_tail] <= '{addr: bus.w_i_addr0, data: bus.w_i_data0};
            end
            if (w_push1) begin
                r_q[w_slot1] <= '{addr: bus.w_i_addr1, data: bus.w_i_data1};
            end
            r_head  <= r_head + PW'(w_pop);
            r_tail  <= r_tail + PW'(w_push0) + PW'(w_push1);
            r_count <= w_count_nxt;
        end
    end

    assign bus.w_o_ready   = w_ready;
    assign bus.w_o_count   = r_count;
    assign bus.w_o_wr_en   = w_pop;
    assign bus.w_o_addr_rd = w_pop ? r_q[r_head].addr : ZERO_REG;
    assign bus.w_o_data_rd = w_pop ? r_q[r_head].data : '0;

`ifdef WB_FWD_EN
    wb_fwd_search #(
        .DEPTH (DEPTH),
        .PW    (PW),
        .CW    (CW)
    ) u_fwd_search (
        .i_entries (r_q),
        .i_head    (r_head),
        .i_count   (r_count),
        .i_addr_q  (bus.w_i_addr_q),
        .o_hit     (bus.w_o_fwd_hit),
        .o_data    (bus.w_o_fwd_data)
    );
`else
    logic w_unused_addr_q;
    assign w_unused_addr_q  = ^bus.w_i_addr_q;
    assign bus.w_o_fwd_hit  = 1'b0;
    assign bus.w_o_fwd_data = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_write_arbiter
// Description : Self-checking bench for wb_write_arbiter. A queue model of
//               pending writes predicts ready/count/forwarding; every accepted
//               non-$zero lane is also pushed to a scoreboard that a monitor
//               pops whenever the DUT asserts its write enable.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_write_arbiter;
    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    logic clk;
    logic rst_n;

    wb_write_arbiter_if #(.DEPTH(DEPTH)) bus ();

    wb_write_arbiter #(.DEPTH(DEPTH)) dut (
        .w_clk   (clk),
        .w_rst_n (rst_n),
        .bus     (bus)
    );

    ent_t        mq[$];      // model of queue contents
    ent_t        sb[$];      // expected write-port sequence
    logic [31:0] regfile [32];
    int          errors = 0;
    int          checks = 0;
    bit          saw_bp = 0;
    logic [4:0]  q_addr = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one drain per edge while non-empty, then accept when
    // at least two slots were free before the edge.
    always @(posedge clk) begin
        if (rst_n) begin
            int  n;
            bit  acc;
            n   = mq.size();
            acc = (DEPTH - n) >= 2;
            if (n != 0) void'(mq.pop_front());
            if (acc) begin
                if (bus.w_i_valid0 && bus.w_i_addr0 != 0) begin
                    mq.push_back('{bus.w_i_addr0, bus.w_i_data0});
                    sb.push_back('{bus.w_i_addr0, bus.w_i_data0});
                end
                if (bus.w_i_valid1 && bus.w_i_addr1 != 0) begin
                    mq.push_back('{bus.w_i_addr1, bus.w_i_data1});
                    sb.push_back('{bus.w_i_addr1, bus.w_i_data1});
                end
            end
        end
    end

    // Monitor: compare each presented write with the scoreboard head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.w_o_wr_en) begin
                if (sb.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    ent_t e;
                    e = sb.pop_front();
                    chk("write_addr", 64'(bus.w_o_addr_rd), 64'(e.addr));
                    chk("write_data", 64'(bus.w_o_data_rd), 64'(e.data));
                    regfile[bus.w_o_addr_rd] = bus.w_o_data_rd;
                end
            end else begin
                chk("missing_write", 64'(sb.size()), 0);
            end
        end
    end

    // One cycle starting at a negedge: check status, drive lanes, check forwarding.
    task automatic drive_cycle(input bit v0, input logic [4:0] a0, input logic [31:0] d0,
                               input bit v1, input logic [4:0] a1, input logic [31:0] d1,
                               output bit acc);
        int          n;
        logic        eh;
        logic [31:0] ed;
        n = mq.size();
        chk("ready", 64'(bus.w_o_ready), 64'((DEPTH - n) >= 2));
        chk("count", 64'(bus.w_o_count), 64'(n));
        if (!bus.w_o_ready) saw_bp = 1;
        bus.w_i_valid0 = v0; bus.w_i_addr0 = a0; bus.w_i_data0 = d0;
        bus.w_i_valid1 = v1; bus.w_i_addr1 = a1; bus.w_i_data1 = d1;
        bus.w_i_addr_q = q_addr;
        #1;
        eh = 1'b0;
        ed = '0;
`ifdef WB_FWD_EN
        if (q_addr != 0) begin
            foreach (mq[i]) begin
                if (mq[i].addr == q_addr) begin
                    eh = 1'b1;
                    ed = mq[i].data;
                end
            end
        end
`endif
        chk("fwd_hit", 64'(bus.w_o_fwd_hit), 64'(eh));
        chk("fwd_data", 64'(bus.w_o_fwd_data), 64'(ed));
        acc = (DEPTH - n) >= 2;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present a pair and hold it until accepted.
    task automatic send(input bit v0, input logic [4:0] a0, input logic [31:0] d0,
                        input bit v1, input logic [4:0] a1, input logic [31:0] d1);
        bit acc;
        int tries;
        acc   = 0;
        tries = 0;
        while (!acc && tries < 20) begin
            drive_cycle(v0, a0, d0, v1, a1, d1, acc);
            tries++;
        end
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) drive_cycle(0, 0, 0, 0, 0, 0, acc);
    endtask

    // Assert reset a few ns after a rising edge and check it acts at once.
    task automatic mid_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        mq.delete();
        sb.delete();
        #1;
        chk("rst_wr_en", 64'(bus.w_o_wr_en), 0);
        chk("rst_count", 64'(bus.w_o_count), 0);
        chk("rst_ready", 64'(bus.w_o_ready), 1);
        chk("rst_addr_rd", 64'(bus.w_o_addr_rd), 0);
        chk("rst_data_rd", 64'(bus.w_o_data_rd), 0);
        chk("rst_fwd_hit", 64'(bus.w_o_fwd_hit), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        for (int i = 0; i < 32; i++) regfile[i] = '0;
        rst_n = 1'b0;
        bus.w_i_valid0 = 0; bus.w_i_addr0 = 0; bus.w_i_data0 = 0;
        bus.w_i_valid1 = 0; bus.w_i_addr1 = 0; bus.w_i_data1 = 0;
        bus.w_i_addr_q = 0;
        #3;
        chk("por_wr_en", 64'(bus.w_o_wr_en), 0);
        chk("por_count", 64'(bus.w_o_count), 0);
        chk("por_ready", 64'(bus.w_o_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        // Single push
        send(1, 5'd5, 32'hA5, 0, 0, 0);
        idle(3);

        // Duplicate rd on both lanes: lane1's value must win
        send(1, 5'd3, 32'h1, 1, 5'd3, 32'h2);
        idle(4);
        chk("reg3_final", 64'(regfile[3]), 64'h2);

        // $zero lane dropped, other lane kept
        send(1, 5'd0, 32'hFF, 1, 5'd9, 32'h9);
        idle(3);
        chk("reg0_untouched", 64'(regfile[0]), 0);
        chk("reg9", 64'(regfile[9]), 64'h9);

        // Backpressure burst
        saw_bp = 0;
        for (int i = 0; i < 4; i++) begin
            send(1, 5'(10 + 2 * i), 32'h100 + 32'(i), 1, 5'(11 + 2 * i), 32'h200 + 32'(i));
        end
        idle(8);
        chk("backpressure_seen", 64'(saw_bp), 1);

        // Forwarding: two pending writes to r7, query r7
        q_addr = 5'd7;
        send(1, 5'd7, 32'h11, 1, 5'd7, 32'h22);
        idle(3);
        q_addr = 5'd0;

        // Reset mid-drain
        send(1, 5'd20, 32'h20, 1, 5'd21, 32'h21);
        send(1, 5'd22, 32'h22, 1, 5'd23, 32'h23);
        chk("queued_before_reset", 64'(bus.w_o_count), 3);
        mid_reset();
        idle(4);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            bit          v0, v1;
            logic [4:0]  a0, a1;
            v0     = ($urandom_range(0, 3) != 0);
            v1     = ($urandom_range(0, 2) != 0);
            a0     = 5'($urandom_range(0, 7));
            a1     = 5'($urandom_range(0, 7));
            q_addr = 5'($urandom_range(0, 7));
            send(v0, a0, $urandom, v1, a1, $urandom);
        end
        q_addr = 5'd0;
        idle(8);
        chk("scoreboard_empty", 64'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
